// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB configuration sequencer.
// Holds the FSM state encoding, the table marker values, the SCCB R/W bit values
// and the index-width helper used by the sequencer and the table ROM.
package sccb_pkg;

    typedef logic [3:0] state_t;

    localparam state_t StIdle   = 4'd0;
    localparam state_t StFetch  = 4'd1;
    localparam state_t StDecode = 4'd2;
    localparam state_t StWrReq  = 4'd3;
    localparam state_t StWrWait = 4'd4;
    localparam state_t StRdReq  = 4'd5;
    localparam state_t StRdWait = 4'd6;
    localparam state_t StCheck  = 4'd7;
    localparam state_t StDelay  = 4'd8;
    localparam state_t StFinish = 4'd9;
    localparam state_t StFault  = 4'd10;

    // Table entry that terminates the sequence.
    localparam logic [15:0] END_MARK   = 16'hFFFF;
    // sub_addr value that turns an entry into a wait of data*DELAY_UNIT ticks.
    localparam logic [7:0]  DELAY_MARK = 8'hFF;

    localparam logic SCCB_WR = 1'b0;
    localparam logic SCCB_RD = 1'b1;

    // Index width; a one-entry table still needs a 1-bit address.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sccb_cfg_rom.sv
// Camera register table: NUM_REGS entries of {sub_addr, data}, registered read.
// Contents come in through INIT (entry i at INIT[16*i +: 16]), which the build
// generates from the camera's hex table so a new sensor only swaps this instance.
// Ports:
//   PCLK     in   system clock
//   PRESETN  in   asynchronous active-low reset
//   addr_i   in   table index
//   data_o   out  entry at addr_i, one PCLK after addr_i changes
module sccb_cfg_rom
    import sccb_pkg::*;
#(
    parameter int unsigned            NUM_REGS = 64,
    parameter int unsigned            IDX_W    = idx_width(NUM_REGS),
    parameter logic [NUM_REGS*16-1:0] INIT     = '1
) (
    input  logic             PCLK,
    input  logic             PRESETN,
    input  logic [IDX_W-1:0] addr_i,
    output logic [15:0]      data_o
);

    logic [15:0] data_q;

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            data_q <= '0;
        end else begin
            data_q <= INIT[{addr_i, 4'b0000} +: 16];
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/sccb_config_seq.sv
// Table-driven SCCB camera configuration sequencer.
// Walks a {sub_addr, data} table, issues one CoreSCCB write per entry, optionally
// reads it back and compares, retrying the write up to MAX_RETRY times, and
// reports completion or the failing entry. Every state/output update is gated by
// mid_pulse_i so the FSM runs at the SCCB bit rate.
// Ports:
//   PCLK, PRESETN       clock, asynchronous active-low reset
//   mid_pulse_i         one-PCLK strobe per SCCB bit period
//   go_i                start request (level, sampled when not busy)
//   tbl_addr_o          table index
//   tbl_data_i          table entry {sub_addr, data}
//   sccb_start_o        CoreSCCB start, held until sccb_done_i is seen
//   sccb_rw_o           0 write, 1 read
//   sccb_ip_addr_o      device address byte including R/W bit
//   sccb_sub_addr_o     register address
//   sccb_data_in_o      write data
//   sccb_done_i         CoreSCCB transaction complete
//   sccb_data_out_i     CoreSCCB read data
//   busy_o              sequence in progress
//   cfg_done_o          sticky: table completed without fault
//   cfg_error_o         sticky: verify failed after all retries
//   err_index_o         failing entry index
//   err_data_o          last read-back value of the failing entry
module sccb_config_seq
    import sccb_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR   = 7'h21,
    parameter int unsigned NUM_REGS   = 64,
    parameter bit          VERIFY     = 1'b1,
    parameter int unsigned MAX_RETRY  = 3,
    parameter int unsigned DELAY_UNIT = 300,
    parameter logic [7:0]  RESET_REG  = 8'h12,
    parameter int unsigned IDX_W      = idx_width(NUM_REGS)
) (
    input  logic             PCLK,
    input  logic             PRESETN,
    input  logic             mid_pulse_i,
    input  logic             go_i,
    output logic [IDX_W-1:0] tbl_addr_o,
    input  logic [15:0]      tbl_data_i,
    output logic             sccb_start_o,
    output logic             sccb_rw_o,
    output logic [7:0]       sccb_ip_addr_o,
    output logic [7:0]       sccb_sub_addr_o,
    output logic [7:0]       sccb_data_in_o,
    input  logic             sccb_done_i,
    input  logic [7:0]       sccb_data_out_i,
    output logic             busy_o,
    output logic             cfg_done_o,
    output logic             cfg_error_o,
    output logic [IDX_W-1:0] err_index_o,
    output logic [7:0]       err_data_o
);

    localparam int unsigned      DCNT_W    = $clog2(255 * DELAY_UNIT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REGS - 1);
    localparam logic [3:0]       RETRY_LIM = 4'(MAX_RETRY);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         sub_q, sub_d;
    logic [7:0]         dat_q, dat_d;
    logic [7:0]         rdata_q, rdata_d;
    logic [3:0]         retry_q, retry_d;
    logic [DCNT_W-1:0]  dcnt_q, dcnt_d;
    logic               start_q, start_d;
    logic               rw_q, rw_d;
    logic [7:0]         ip_q, ip_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic [IDX_W-1:0]   err_idx_q, err_idx_d;
    logic [7:0]         err_dat_q, err_dat_d;
    logic               advance;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        sub_d     = sub_q;
        dat_d     = dat_q;
        rdata_d   = rdata_q;
        retry_d   = retry_q;
        dcnt_d    = dcnt_q;
        start_d   = start_q;
        rw_d      = rw_q;
        ip_d      = ip_q;
        busy_d    = busy_q;
        done_d    = done_q;
        error_d   = error_q;
        err_idx_d = err_idx_q;
        err_dat_d = err_dat_q;
        advance   = 1'b0;

        case (state_q)
            StIdle, StFinish, StFault: begin
                if (go_i) begin
                    done_d    = 1'b0;
                    error_d   = 1'b0;
                    err_idx_d = '0;
                    err_dat_d = '0;
                    idx_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = StFetch;
                end
            end
            // tbl_addr_o already shows idx_q; this slot lets the ROM data settle.
            StFetch: state_d = StDecode;
            StDecode: begin
                if (tbl_data_i == END_MARK) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StFinish;
                end else if (tbl_data_i[15:8] == DELAY_MARK) begin
                    dcnt_d  = DCNT_W'(tbl_data_i[7:0]) * DCNT_W'(DELAY_UNIT);
                    state_d = StDelay;
                end else begin
                    sub_d   = tbl_data_i[15:8];
                    dat_d   = tbl_data_i[7:0];
                    retry_d = '0;
                    state_d = StWrReq;
                end
            end
            StWrReq: begin
                start_d = 1'b1;
                rw_d    = SCCB_WR;
                ip_d    = {DEV_ADDR, SCCB_WR};
                state_d = StWrWait;
            end
            StWrWait: begin
                if (sccb_done_i) begin
                    start_d = 1'b0;
                    // The soft-reset register clears itself, so reading it back is meaningless.
                    if (!VERIFY || (sub_q == RESET_REG)) begin
                        advance = 1'b1;
                    end else begin
                        state_d = StRdReq;
                    end
                end
            end
            StRdReq: begin
                start_d = 1'b1;
                rw_d    = SCCB_RD;
                ip_d    = {DEV_ADDR, SCCB_RD};
                state_d = StRdWait;
            end
            StRdWait: begin
                if (sccb_done_i) begin
                    start_d = 1'b0;
                    rdata_d = sccb_data_out_i;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (rdata_q == dat_q) begin
                    advance = 1'b1;
                end else if (retry_q < RETRY_LIM) begin
                    retry_d = retry_q + 4'd1;
                    state_d = StWrReq;
                end else begin
                    error_d   = 1'b1;
                    err_idx_d = idx_q;
                    err_dat_d = rdata_q;
                    busy_d    = 1'b0;
                    state_d   = StFault;
                end
            end
            StDelay: begin
                if (dcnt_q == '0) begin
                    advance = 1'b1;
                end else begin
                    dcnt_d = dcnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // A full table ends the sequence without wrapping the index.
        if (advance) begin
            if (idx_q == LAST_IDX) begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StFinish;
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = StFetch;
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            sub_q     <= '0;
            dat_q     <= '0;
            rdata_q   <= '0;
            retry_q   <= '0;
            dcnt_q    <= '0;
            start_q   <= 1'b0;
            rw_q      <= 1'b0;
            ip_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            err_idx_q <= '0;
            err_dat_q <= '0;
        end else if (mid_pulse_i) begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            sub_q     <= sub_d;
            dat_q     <= dat_d;
            rdata_q   <= rdata_d;
            retry_q   <= retry_d;
            dcnt_q    <= dcnt_d;
            start_q   <= start_d;
            rw_q      <= rw_d;
            ip_q      <= ip_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            err_idx_q <= err_idx_d;
            err_dat_q <= err_dat_d;
        end
    end

    assign tbl_addr_o      = idx_q;
    assign sccb_start_o    = start_q;
    assign sccb_rw_o       = rw_q;
    assign sccb_ip_addr_o  = ip_q;
    assign sccb_sub_addr_o = sub_q;
    assign sccb_data_in_o  = dat_q;
    assign busy_o          = busy_q;
    assign cfg_done_o      = done_q;
    assign cfg_error_o     = error_q;
    assign err_index_o     = err_idx_q;
    assign err_data_o      = err_dat_q;

endmodule

// File: tb/tb_sccb_config_seq.sv
// Directed bench for sccb_config_seq: a CoreSCCB model (done 4 mid_pulses after
// start, register-file echo with injectable bad read-backs) and hand-computed
// expectations for each table.
module tb_sccb_config_seq;

    logic        pclk;
    logic        presetn;
    logic        mid;
    logic        go;
    logic        go4;
    logic [5:0]  tbl_addr;
    logic [15:0] tbl_data;
    logic        start, rw, done;
    logic [7:0]  ip, sub, din, dout;
    logic        busy, cfg_done, cfg_error;
    logic [5:0]  err_index;
    logic [7:0]  err_data;

    logic [1:0]  tbl_addr4;
    logic [15:0] tbl_data4;
    logic        start4, rw4, done4;
    logic [7:0]  ip4, sub4, din4;
    logic        busy4, cfg_done4, cfg_error4;
    logic [1:0]  err_index4;
    logic [7:0]  err_data4;

    int total = 0;
    int bad   = 0;

    logic [15:0] tbl [64];

    // Model configuration (bench-written only).
    logic [7:0] bad_reg;
    logic [7:0] bad_val;
    int         bad_limit;

    // Model state.
    logic [7:0] regs [256];
    int         cnt, wr_n, rd_n, wr_bad_n, bad_used, gap_cnt, gap_n;
    int         gap_log [8];
    logic       ip_bad;
    logic [7:0] first_sub;
    int         cnt4, wr4_n;
    logic [7:0] last_sub4;

    sccb_config_seq u_dut (
        .PCLK            (pclk),
        .PRESETN         (presetn),
        .mid_pulse_i     (mid),
        .go_i            (go),
        .tbl_addr_o      (tbl_addr),
        .tbl_data_i      (tbl_data),
        .sccb_start_o    (start),
        .sccb_rw_o       (rw),
        .sccb_ip_addr_o  (ip),
        .sccb_sub_addr_o (sub),
        .sccb_data_in_o  (din),
        .sccb_done_i     (done),
        .sccb_data_out_i (dout),
        .busy_o          (busy),
        .cfg_done_o      (cfg_done),
        .cfg_error_o     (cfg_error),
        .err_index_o     (err_index),
        .err_data_o      (err_data)
    );

    sccb_config_seq #(
        .NUM_REGS (4),
        .VERIFY   (1'b0)
    ) u_dut4 (
        .PCLK            (pclk),
        .PRESETN         (presetn),
        .mid_pulse_i     (mid),
        .go_i            (go4),
        .tbl_addr_o      (tbl_addr4),
        .tbl_data_i      (tbl_data4),
        .sccb_start_o    (start4),
        .sccb_rw_o       (rw4),
        .sccb_ip_addr_o  (ip4),
        .sccb_sub_addr_o (sub4),
        .sccb_data_in_o  (din4),
        .sccb_done_i     (done4),
        .sccb_data_out_i (8'h00),
        .busy_o          (busy4),
        .cfg_done_o      (cfg_done4),
        .cfg_error_o     (cfg_error4),
        .err_index_o     (err_index4),
        .err_data_o      (err_data4)
    );

    // Full table, no END_MARK.
    sccb_cfg_rom #(
        .NUM_REGS (4),
        .INIT     (64'h0404_0303_0202_0101)
    ) u_rom4 (
        .PCLK    (pclk),
        .PRESETN (presetn),
        .addr_i  (tbl_addr4),
        .data_o  (tbl_data4)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    // mid_pulse every third PCLK, changing 1 ns after the edge.
    initial begin
        int mc;
        mc  = 0;
        mid = 1'b0;
        forever begin
            @(posedge pclk);
            #1;
            mc  = (mc + 1) % 3;
            mid = (mc == 0);
        end
    end

    always @(posedge pclk) tbl_data <= tbl[tbl_addr];

    // CoreSCCB model for the main DUT; also logs idle gaps between transactions.
    always @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            done <= 1'b0; dout <= '0; cnt <= 0; wr_n <= 0; rd_n <= 0; wr_bad_n <= 0;
            bad_used <= 0; gap_cnt <= 0; gap_n <= 0; ip_bad <= 1'b0; first_sub <= '0;
        end else if (mid) begin
            if (!start) begin
                done    <= 1'b0;
                cnt     <= 0;
                gap_cnt <= gap_cnt + 1;
            end else begin
                if (gap_cnt != 0) begin
                    if (gap_n < 8) gap_log[gap_n] <= gap_cnt;
                    gap_n   <= gap_n + 1;
                    gap_cnt <= 0;
                end
                if (!done) begin
                    if (cnt == 3) begin
                        done <= 1'b1;
                        if (!rw) begin
                            regs[sub] <= din;
                            wr_n      <= wr_n + 1;
                            if (wr_n == 0) first_sub <= sub;
                            if (sub == bad_reg) wr_bad_n <= wr_bad_n + 1;
                            if (ip != 8'h42) ip_bad <= 1'b1;
                        end else begin
                            rd_n <= rd_n + 1;
                            if (ip != 8'h43) ip_bad <= 1'b1;
                            if (sub == bad_reg && bad_used < bad_limit) begin
                                dout     <= bad_val;
                                bad_used <= bad_used + 1;
                            end else begin
                                dout <= regs[sub];
                            end
                        end
                    end else begin
                        cnt <= cnt + 1;
                    end
                end
            end
        end
    end

    // Write-only CoreSCCB model for the 4-entry DUT.
    always @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            done4 <= 1'b0; cnt4 <= 0; wr4_n <= 0; last_sub4 <= '0;
        end else if (mid) begin
            if (!start4) begin
                done4 <= 1'b0;
                cnt4  <= 0;
            end else if (!done4) begin
                if (cnt4 == 3) begin
                    done4     <= 1'b1;
                    wr4_n     <= wr4_n + 1;
                    last_sub4 <= sub4;
                end else begin
                    cnt4 <= cnt4 + 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Return just after a PCLK edge on which mid was high.
    task automatic wait_mid();
        do @(posedge pclk); while (!mid);
        #2;
    endtask

    task automatic pulse_go(input int which);
        if (which == 0) go = 1'b1; else go4 = 1'b1;
        wait_mid();
        go  = 1'b0;
        go4 = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int which);
        int n;
        n = 0;
        while (((which == 0) ? busy : busy4) && n < 5000) begin
            @(posedge pclk);
            n++;
        end
        #2;
        chk({tag, "_timeout"}, 32'(n < 5000), 32'd1);
    endtask

    task automatic do_reset();
        presetn = 1'b0;
        go      = 1'b0;
        go4     = 1'b0;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        presetn = 1'b1;
    endtask

    task automatic clear_tbl();
        for (int i = 0; i < 64; i++) tbl[i] = 16'hFFFF;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        bad_reg   = 8'h00;
        bad_val   = 8'h00;
        bad_limit = 0;
        clear_tbl();
        presetn = 1'b0;
        go      = 1'b0;
        go4     = 1'b0;
        repeat (3) @(posedge pclk);
        #2;
        // Reset state.
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_done", 32'(cfg_done), 32'd0);
        chk("rst_error", 32'(cfg_error), 32'd0);
        chk("rst_addr", 32'(tbl_addr), 32'd0);
        chk("rst_ip", 32'(ip), 32'd0);
        @(negedge pclk);
        presetn = 1'b1;

        // Soft-reset write (no readback), 1 x 300-tick delay, verified write.
        tbl[0] = 16'h1280; tbl[1] = 16'hFF01; tbl[2] = 16'h1101; tbl[3] = 16'hFFFF;
        pulse_go(0);
        chk("t1_busy", 32'(busy), 32'd1);
        repeat (30) wait_mid();
        pulse_go(0);  // ignored while busy
        chk("t1_go_busy", 32'(busy), 32'd1);
        wait_idle("t1", 0);
        chk("t1_done", 32'(cfg_done), 32'd1);
        chk("t1_error", 32'(cfg_error), 32'd0);
        chk("t1_writes", 32'(wr_n), 32'd2);
        chk("t1_reads", 32'(rd_n), 32'd1);
        chk("t1_reg11", 32'(regs[8'h11]), 32'h01);
        chk("t1_reg12", 32'(regs[8'h12]), 32'h80);
        chk("t1_delay_gap", 32'(gap_log[1]), 32'd306);
        chk("t1_rd_gap", 32'(gap_log[2]), 32'd1);
        chk("t1_ipaddr", 32'(ip_bad), 32'd0);

        // Two bad read-backs of 0x3A, then a match.
        do_reset();
        clear_tbl();
        tbl[0]    = 16'h3A04;
        bad_reg   = 8'h3A;
        bad_val   = 8'h00;
        bad_limit = 2;
        pulse_go(0);
        wait_idle("t2", 0);
        chk("t2_done", 32'(cfg_done), 32'd1);
        chk("t2_error", 32'(cfg_error), 32'd0);
        chk("t2_writes", 32'(wr_bad_n), 32'd3);
        chk("t2_reads", 32'(rd_n), 32'd3);

        // Entry 2 never verifies: 1 + MAX_RETRY writes, then FAULT.
        do_reset();
        clear_tbl();
        tbl[0] = 16'h1101; tbl[1] = 16'h1302; tbl[2] = 16'h3B0A;
        bad_reg   = 8'h3B;
        bad_val   = 8'h5A;
        bad_limit = 1000;
        pulse_go(0);
        wait_idle("t3", 0);
        chk("t3_error", 32'(cfg_error), 32'd1);
        chk("t3_done", 32'(cfg_done), 32'd0);
        chk("t3_err_index", 32'(err_index), 32'd2);
        chk("t3_err_data", 32'(err_data), 32'h5A);
        chk("t3_bad_writes", 32'(wr_bad_n), 32'd4);
        chk("t3_writes", 32'(wr_n), 32'd6);
        // Rerun after FAULT clears the sticky error.
        bad_limit = 0;
        pulse_go(0);
        chk("t3_rerun_error", 32'(cfg_error), 32'd0);
        chk("t3_rerun_busy", 32'(busy), 32'd1);
        chk("t3_rerun_err_index", 32'(err_index), 32'd0);
        wait_idle("t3_rerun", 0);
        chk("t3_rerun_done", 32'(cfg_done), 32'd1);
        chk("t3_rerun_writes", 32'(wr_n), 32'd9);

        // Reset while waiting for a write to complete.
        do_reset();
        clear_tbl();
        tbl[0] = 16'h1101;
        pulse_go(0);
        n = 0;
        while (!start && n < 200) begin
            @(posedge pclk);
            n++;
        end
        chk("t5_start_seen", 32'(n < 200), 32'd1);
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        presetn = 1'b0;
        #1;
        chk("t5_start_drop", 32'(start), 32'd0);
        chk("t5_busy_drop", 32'(busy), 32'd0);
        @(negedge pclk);
        presetn = 1'b1;
        pulse_go(0);
        chk("t5_restart_addr", 32'(tbl_addr), 32'd0);
        wait_idle("t5", 0);
        chk("t5_done", 32'(cfg_done), 32'd1);
        chk("t5_writes", 32'(wr_n), 32'd1);
        chk("t5_first_sub", 32'(first_sub), 32'h11);

        // Full 4-entry table without END_MARK.
        do_reset();
        chk("t6_rst_busy", 32'(busy4), 32'd0);
        pulse_go(1);
        wait_idle("t6", 1);
        chk("t6_done", 32'(cfg_done4), 32'd1);
        chk("t6_error", 32'(cfg_error4), 32'd0);
        chk("t6_writes", 32'(wr4_n), 32'd4);
        chk("t6_last_sub", 32'(last_sub4), 32'h04);
        chk("t6_addr", 32'(tbl_addr4), 32'd3);
        repeat (5) wait_mid();
        chk("t6_addr_hold", 32'(tbl_addr4), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
